// File: rtl/xrst_settlement_pkg.sv
// Shared types and constants for the XRST settlement calculator.
// Holds the FSM state enum, SLA tier codes, status bit positions, tier
// thresholds/percentages and the iterative divider geometry.
package xrst_settlement_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DIV_W          = 40;
  localparam int unsigned DIV_CYCLES     = 40;
  localparam int unsigned CNT_W          = $clog2(DIV_CYCLES + 1);
  localparam int unsigned STATUS_W       = 8;
  localparam int unsigned STATUS_CAP_BIT = 7;
  localparam int unsigned PCT_W          = 7;

  localparam int unsigned TH_OK       = 950;
  localparam int unsigned TH_MINOR    = 900;
  localparam int unsigned TH_MAJOR    = 800;
  localparam int unsigned PCT_OK      = 0;
  localparam int unsigned PCT_MINOR   = 5;
  localparam int unsigned PCT_MAJOR   = 20;
  localparam int unsigned PCT_CRIT    = 50;
  localparam int unsigned SPLIT_A_PCT = 60;
  localparam int unsigned SPLIT_B_PCT = 30;

  localparam logic [DATA_W-1:0] DIVISOR = 32'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_PEN,
    ST_DIV_A,
    ST_DIV_B,
    ST_EMIT
  } state_e;

  typedef enum logic [1:0] {
    TIER_OK    = 2'b00,
    TIER_MINOR = 2'b01,
    TIER_MAJOR = 2'b10,
    TIER_CRIT  = 2'b11
  } tier_e;

  // Request fields captured on the accept edge.
  typedef struct packed {
    logic [DATA_W-1:0] stake;
    logic [DATA_W-1:0] score;
    logic [DATA_W-1:0] sla_id;
    logic [DATA_W-1:0] timestamp;
  } req_t;

  // Scores above the nominal 1000 range fall into the OK tier naturally.
  function automatic tier_e score_tier(input logic [DATA_W-1:0] score);
    if (score >= TH_OK)         return TIER_OK;
    else if (score >= TH_MINOR) return TIER_MINOR;
    else if (score >= TH_MAJOR) return TIER_MAJOR;
    else                        return TIER_CRIT;
  endfunction

  function automatic logic [PCT_W-1:0] tier_pct(input tier_e tier);
    case (tier)
      TIER_OK:    return PCT_W'(PCT_OK);
      TIER_MINOR: return PCT_W'(PCT_MINOR);
      TIER_MAJOR: return PCT_W'(PCT_MAJOR);
      default:    return PCT_W'(PCT_CRIT);
    endcase
  endfunction

endpackage

// File: rtl/xrst_iter_div.sv
// Restoring iterative divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so the full quotient is
// registered DIV_CYCLES-1 edges later and done_o pulses in that cycle; a
// consumer sampling done_o sees it exactly DIV_CYCLES edges after start.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      load dividend and begin (may coincide with done_o)
//   dividend_i   DIV_W-bit dividend
//   divisor_i    DATA_W-bit divisor (nonzero)
//   busy_o       iteration in progress
//   done_o       one-cycle pulse, quotient_o valid
//   quotient_o   low DATA_W bits of the quotient
module xrst_iter_div
  import xrst_settlement_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DIV_W-1:0]  dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o
);

  logic [DIV_W-1:0]  quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] src_rem;
  logic [DIV_W-1:0]  src_quot;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              ge;

  // One restoring step, sourced from the new operand on start.
  always_comb begin
    src_rem  = start_i ? '0 : rem_q;
    src_quot = start_i ? dividend_i : quot_q;
    trial    = {src_rem, src_quot[DIV_W-1]};
    diff     = trial - {1'b0, divisor_i};
    ge       = (trial >= {1'b0, divisor_i});

    quot_d = quot_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start_i) begin
      quot_d = {src_quot[DIV_W-2:0], ge};
      rem_d  = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
      cnt_d  = CNT_W'(DIV_CYCLES - 1);
    end else if (cnt_q != '0) begin
      quot_d = {src_quot[DIV_W-2:0], ge};
      rem_d  = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quot_q[DATA_W-1:0];

endmodule

// File: rtl/xrst_settlement_calculator.sv
// XRST settlement calculator: one SLA evaluation (stake, score) becomes a
// tiered penalty split three ways (A, B, C takes the remainder) plus the
// remaining stake. All division by 100 goes through one shared iterative
// divider, giving a fixed 120-cycle latency from accept to settlement_valid.
// Optional feature: define XRST_PENALTY_CAP_EN to clamp the penalty at
// PENALTY_CAP and flag the clamp in sla_status[7].
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake, ready only in IDLE
//   stake, reliability_score      evaluation inputs
//   sla_id_i, timestamp_i         tags captured at accept
//   settlement_a/b/c              payouts
//   remaining_stake               stake - penalty
//   sla_status                    [1:0] tier, [7] penalty capped
//   sla_id_o, timestamp_o,
//   reliability_score_o           captured tags, presented with the result
//   settlement_valid              one-cycle result strobe
module xrst_settlement_calculator
  import xrst_settlement_pkg::*;
`ifdef XRST_PENALTY_CAP_EN
#(
  parameter logic [DATA_W-1:0] PENALTY_CAP = 32'd100000
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   stake,
  input  logic [DATA_W-1:0]   reliability_score,
  input  logic [DATA_W-1:0]   sla_id_i,
  input  logic [DATA_W-1:0]   timestamp_i,
  output logic [DATA_W-1:0]   settlement_a,
  output logic [DATA_W-1:0]   settlement_b,
  output logic [DATA_W-1:0]   settlement_c,
  output logic [DATA_W-1:0]   remaining_stake,
  output logic [STATUS_W-1:0] sla_status,
  output logic [DATA_W-1:0]   sla_id_o,
  output logic [DATA_W-1:0]   timestamp_o,
  output logic [DATA_W-1:0]   reliability_score_o,
  output logic                settlement_valid
);

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  tier_e               tier_q, tier_d;
  logic [DATA_W-1:0]   penalty_q, penalty_d;
  logic [DATA_W-1:0]   part_a_q, part_a_d;
  logic                capped_q, capped_d;

  logic [DATA_W-1:0]   set_a_q, set_a_d;
  logic [DATA_W-1:0]   set_b_q, set_b_d;
  logic [DATA_W-1:0]   set_c_q, set_c_d;
  logic [DATA_W-1:0]   remain_q, remain_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [DATA_W-1:0]   id_out_q, id_out_d;
  logic [DATA_W-1:0]   ts_out_q, ts_out_d;
  logic [DATA_W-1:0]   score_out_q, score_out_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;

  logic                div_start;
  logic [DIV_W-1:0]    div_dividend;
  logic                div_busy;
  logic                div_done;
  logic [DATA_W-1:0]   div_quot;
  logic [DATA_W-1:0]   pen_sel;
  logic                pen_clamp;
  tier_e               new_tier;

  xrst_iter_div u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (DIVISOR),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // Penalty as it leaves the first division, optionally clamped.
  always_comb begin
    pen_sel   = div_quot;
    pen_clamp = 1'b0;
`ifdef XRST_PENALTY_CAP_EN
    if (div_quot > PENALTY_CAP) begin
      pen_sel   = PENALTY_CAP;
      pen_clamp = 1'b1;
    end
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    tier_d       = tier_q;
    penalty_d    = penalty_q;
    part_a_d     = part_a_q;
    capped_d     = capped_q;
    set_a_d      = set_a_q;
    set_b_d      = set_b_q;
    set_c_d      = set_c_q;
    remain_d     = remain_q;
    status_d     = status_q;
    id_out_d     = id_out_q;
    ts_out_d     = ts_out_q;
    score_out_d  = score_out_q;
    valid_d      = 1'b0;
    ready_d      = ready_q;
    div_start    = 1'b0;
    div_dividend = '0;
    new_tier     = score_tier(reliability_score);

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          req_d        = '{stake: stake, score: reliability_score,
                           sla_id: sla_id_i, timestamp: timestamp_i};
          tier_d       = new_tier;
          div_start    = 1'b1;
          div_dividend = DIV_W'(stake) * DIV_W'(tier_pct(new_tier));
          ready_d      = 1'b0;
          state_d      = ST_DIV_PEN;
        end
      end
      ST_DIV_PEN: begin
        if (div_done) begin
          penalty_d    = pen_sel;
          capped_d     = pen_clamp;
          div_start    = 1'b1;
          div_dividend = DIV_W'(pen_sel) * DIV_W'(SPLIT_A_PCT);
          state_d      = ST_DIV_A;
        end
      end
      ST_DIV_A: begin
        if (div_done) begin
          part_a_d     = div_quot;
          div_start    = 1'b1;
          div_dividend = DIV_W'(penalty_q) * DIV_W'(SPLIT_B_PCT);
          state_d      = ST_DIV_B;
        end
      end
      ST_DIV_B: begin
        // C absorbs both truncation remainders, so the split always conserves.
        if (div_done) begin
          set_a_d     = part_a_q;
          set_b_d     = div_quot;
          set_c_d     = penalty_q - part_a_q - div_quot;
          remain_d    = req_q.stake - penalty_q;
          status_d    = {capped_q, 5'b0, tier_q};
          id_out_d    = req_q.sla_id;
          ts_out_d    = req_q.timestamp;
          score_out_d = req_q.score;
          valid_d     = 1'b1;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      tier_q      <= TIER_OK;
      penalty_q   <= '0;
      part_a_q    <= '0;
      capped_q    <= 1'b0;
      set_a_q     <= '0;
      set_b_q     <= '0;
      set_c_q     <= '0;
      remain_q    <= '0;
      status_q    <= '0;
      id_out_q    <= '0;
      ts_out_q    <= '0;
      score_out_q <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tier_q      <= tier_d;
      penalty_q   <= penalty_d;
      part_a_q    <= part_a_d;
      capped_q    <= capped_d;
      set_a_q     <= set_a_d;
      set_b_q     <= set_b_d;
      set_c_q     <= set_c_d;
      remain_q    <= remain_d;
      status_q    <= status_d;
      id_out_q    <= id_out_d;
      ts_out_q    <= ts_out_d;
      score_out_q <= score_out_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready           = ready_q;
  assign settlement_a        = set_a_q;
  assign settlement_b        = set_b_q;
  assign settlement_c        = set_c_q;
  assign remaining_stake     = remain_q;
  assign sla_status          = status_q;
  assign sla_id_o            = id_out_q;
  assign timestamp_o         = ts_out_q;
  assign reliability_score_o = score_out_q;
  assign settlement_valid    = valid_q;

endmodule

// File: tb/tb_xrst_settlement_calculator.sv
// Directed bench for xrst_settlement_calculator. Inputs change 1ns after
// the rising edge; outputs are sampled at that point too.
module tb_xrst_settlement_calculator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] stake;
  logic [31:0] reliability_score;
  logic [31:0] sla_id_i;
  logic [31:0] timestamp_i;
  logic [31:0] settlement_a;
  logic [31:0] settlement_b;
  logic [31:0] settlement_c;
  logic [31:0] remaining_stake;
  logic [7:0]  sla_status;
  logic [31:0] sla_id_o;
  logic [31:0] timestamp_o;
  logic [31:0] reliability_score_o;
  logic        settlement_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef XRST_PENALTY_CAP_EN
  xrst_settlement_calculator #(.PENALTY_CAP(32'd100)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .stake               (stake),
    .reliability_score   (reliability_score),
    .sla_id_i            (sla_id_i),
    .timestamp_i         (timestamp_i),
    .settlement_a        (settlement_a),
    .settlement_b        (settlement_b),
    .settlement_c        (settlement_c),
    .remaining_stake     (remaining_stake),
    .sla_status          (sla_status),
    .sla_id_o            (sla_id_o),
    .timestamp_o         (timestamp_o),
    .reliability_score_o (reliability_score_o),
    .settlement_valid    (settlement_valid)
  );
`else
  xrst_settlement_calculator dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .stake               (stake),
    .reliability_score   (reliability_score),
    .sla_id_i            (sla_id_i),
    .timestamp_i         (timestamp_i),
    .settlement_a        (settlement_a),
    .settlement_b        (settlement_b),
    .settlement_c        (settlement_c),
    .remaining_stake     (remaining_stake),
    .sla_status          (sla_status),
    .sla_id_o            (sla_id_o),
    .timestamp_o         (timestamp_o),
    .reliability_score_o (reliability_score_o),
    .settlement_valid    (settlement_valid)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and observe the following 125 cycles.
  task automatic do_req(input logic [31:0] st, input logic [31:0] sc,
                        input logic [31:0] id, input logic [31:0] ts,
                        output bit acc_ok, output int lat, output int pulses,
                        output bit ready_ok,
                        output logic [31:0] o_a, output logic [31:0] o_b,
                        output logic [31:0] o_c, output logic [31:0] o_rem,
                        output logic [7:0] o_st, output logic [31:0] o_id,
                        output logic [31:0] o_ts, output logic [31:0] o_sc);
    int w;
    w = 0; acc_ok = 0; lat = -1; pulses = 0; ready_ok = 1;
    o_a = '0; o_b = '0; o_c = '0; o_rem = '0; o_st = '0;
    o_id = '0; o_ts = '0; o_sc = '0;
    stake = st; reliability_score = sc; sla_id_i = id; timestamp_i = ts;
    req_valid = 1'b1;
    while (!req_ready && w < 300) begin
      tick();
      w++;
    end
    if (req_ready) begin
      acc_ok = 1;
      tick();
      req_valid = 1'b0;
      if (req_ready) ready_ok = 0;
      for (int k = 1; k <= 125; k++) begin
        tick();
        if (settlement_valid) begin
          pulses++;
          if (lat < 0) begin
            lat = k;
            o_a = settlement_a; o_b = settlement_b; o_c = settlement_c;
            o_rem = remaining_stake; o_st = sla_status; o_id = sla_id_o;
            o_ts = timestamp_o; o_sc = reliability_score_o;
          end
        end
        if (k <= 120 && req_ready) ready_ok = 0;
        if (k == 121 && !req_ready) ready_ok = 0;
      end
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // Run one vector; exp_pen is the uncapped penalty, used to derive the
  // clamped expectation (cap 100 -> 60/30/10) when the cap feature is built.
  task automatic run_vector(input string nm, input logic [31:0] st,
                            input logic [31:0] sc, input logic [31:0] exp_pen,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ec, input logic [31:0] er,
                            input logic [7:0] es);
    bit acc_ok, ready_ok;
    int lat, pulses;
    logic [31:0] a, b, c, rem, id, ts, scr, xa, xb, xc, xr, tid, tts;
    logic [7:0]  s, xs;
    xa = ea; xb = eb; xc = ec; xr = er; xs = es;
`ifdef XRST_PENALTY_CAP_EN
    if (exp_pen > 32'd100) begin
      xa = 32'd60; xb = 32'd30; xc = 32'd10; xr = st - 32'd100; xs = es | 8'h80;
    end
`else
    if (exp_pen > 32'd100) xs = es;
`endif
    tid = 32'hA000_0000 ^ st ^ sc;
    tts = 32'h0000_1234 + sc;
    do_req(st, sc, tid, tts, acc_ok, lat, pulses, ready_ok,
           a, b, c, rem, s, id, ts, scr);
    checks++;
    if (!acc_ok || lat !== 120 || pulses !== 1 || !ready_ok) begin
      failures++;
      $display("FAIL %s timing: accepted=%0d latency=%0d pulses=%0d ready_ok=%0d required 1/120/1/1",
               nm, acc_ok, lat, pulses, ready_ok);
    end
    checks++;
    if ({a, b, c, rem} !== {xa, xb, xc, xr}) begin
      failures++;
      $display("FAIL %s split: a=%0d b=%0d c=%0d rem=%0d required a=%0d b=%0d c=%0d rem=%0d",
               nm, a, b, c, rem, xa, xb, xc, xr);
    end
    checks++;
    if (s !== xs) begin
      failures++;
      $display("FAIL %s status: got %h required %h", nm, s, xs);
    end
    checks++;
    if (id !== tid || ts !== tts || scr !== sc) begin
      failures++;
      $display("FAIL %s tags: id=%h ts=%h score=%0d required id=%h ts=%h score=%0d",
               nm, id, ts, scr, tid, tts, sc);
    end
    checks++;
    if ({settlement_a, settlement_b, settlement_c, remaining_stake, sla_status} !==
        {xa, xb, xc, xr, xs}) begin
      failures++;
      $display("FAIL %s hold: a=%0d b=%0d c=%0d rem=%0d st=%h after emit",
               nm, settlement_a, settlement_b, settlement_c, remaining_stake, sla_status);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; stake = '0; reliability_score = '0;
    sla_id_i = '0; timestamp_i = '0;
    tick(); tick();
    checks++;
    if ({settlement_a, settlement_b, settlement_c, remaining_stake, sla_status,
         sla_id_o, timestamp_o, reliability_score_o, settlement_valid} !== '0 ||
        req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: a=%0d b=%0d c=%0d rem=%0d st=%h valid=%b ready=%b required zeros and ready=1",
               settlement_a, settlement_b, settlement_c, remaining_stake, sla_status,
               settlement_valid, req_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || settlement_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0",
               req_ready, settlement_valid);
    end
  endtask

  task automatic test_tiers();
    run_vector("major_850", 32'd1000, 32'd850, 32'd200, 32'd120, 32'd60, 32'd20, 32'd800, 8'h02);
    run_vector("ok_960", 32'd5000, 32'd960, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5000, 8'h00);
    run_vector("crit_500", 32'd1000, 32'd500, 32'd500, 32'd300, 32'd150, 32'd50, 32'd500, 8'h03);
  endtask

  task automatic test_boundaries();
    run_vector("minor_900", 32'd1000, 32'd900, 32'd50, 32'd30, 32'd15, 32'd5, 32'd950, 8'h01);
    run_vector("major_899", 32'd100, 32'd899, 32'd20, 32'd12, 32'd6, 32'd2, 32'd80, 8'h02);
    run_vector("ok_950", 32'd400, 32'd950, 32'd0, 32'd0, 32'd0, 32'd0, 32'd400, 8'h00);
    run_vector("crit_799", 32'd100, 32'd799, 32'd50, 32'd30, 32'd15, 32'd5, 32'd50, 8'h03);
    run_vector("ok_2000", 32'd300, 32'd2000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd300, 8'h00);
  endtask

  task automatic test_edge_values();
    run_vector("zero_stake", 32'd0, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h03);
    run_vector("truncation", 32'd7, 32'd850, 32'd1, 32'd0, 32'd0, 32'd1, 32'd6, 8'h02);
    run_vector("max_stake", 32'hFFFF_FFFF, 32'd100, 32'd2147483647,
               32'd1288490188, 32'd644245094, 32'd214748365, 32'd2147483648, 8'h03);
  endtask

  task automatic test_back_to_back();
    int w, pulses, first_k, second_k;
    bit ready_ok;
    logic [31:0] a1, r1, a2, b2, c2, r2;
    logic [7:0]  s1, s2;
    w = 0; pulses = 0; first_k = -1; second_k = -1; ready_ok = 1;
    a1 = '0; r1 = '0; a2 = '0; b2 = '0; c2 = '0; r2 = '0; s1 = '0; s2 = '0;
    stake = 32'd500; reliability_score = 32'd850; sla_id_i = 32'd1; timestamp_i = 32'd2;
    req_valid = 1'b1;
    while (!req_ready && w < 300) begin
      tick();
      w++;
    end
    tick();
    // Inputs change while busy; the first result must use the captured ones.
    stake = 32'd2000; reliability_score = 32'd920;
    if (req_ready) ready_ok = 0;
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (settlement_valid) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k; a1 = settlement_a; r1 = remaining_stake; s1 = sla_status;
        end else begin
          second_k = k; a2 = settlement_a; b2 = settlement_b; c2 = settlement_c;
          r2 = remaining_stake; s2 = sla_status;
        end
      end
      if (k <= 120 && req_ready) ready_ok = 0;
      if (k == 121 && !req_ready) ready_ok = 0;
      if (k == 122) begin
        if (req_ready) ready_ok = 0;
        req_valid = 1'b0;
      end
    end
    checks++;
    if (!ready_ok) begin
      failures++;
      $display("FAIL b2b_ready: req_ready profile wrong, required low through emit, high for one idle cycle, then low");
    end
    checks++;
    if (pulses !== 2 || first_k !== 120 || second_k !== 242) begin
      failures++;
      $display("FAIL b2b_pulses: pulses=%0d first=%0d second=%0d required 2/120/242",
               pulses, first_k, second_k);
    end
    checks++;
    if (a1 !== 32'd60 || r1 !== 32'd400 || s1 !== 8'h02) begin
      failures++;
      $display("FAIL b2b_first: a=%0d rem=%0d st=%h required a=60 rem=400 st=02", a1, r1, s1);
    end
    checks++;
    if ({a2, b2, c2, r2, s2} !== {32'd60, 32'd30, 32'd10, 32'd1900, 8'h01}) begin
      failures++;
      $display("FAIL b2b_second: a=%0d b=%0d c=%0d rem=%0d st=%h required 60/30/10/1900/01",
               a2, b2, c2, r2, s2);
    end
  endtask

  task automatic test_cap();
`ifdef XRST_PENALTY_CAP_EN
    run_vector("cap_500", 32'd1000, 32'd500, 32'd500, 32'd300, 32'd150, 32'd50, 32'd500, 8'h03);
    run_vector("cap_exact", 32'd500, 32'd500, 32'd250, 32'd150, 32'd75, 32'd25, 32'd250, 8'h03);
`else
    run_vector("nocap_500", 32'd1000, 32'd500, 32'd500, 32'd300, 32'd150, 32'd50, 32'd500, 8'h03);
`endif
  endtask

  task automatic test_reset_midop();
    int w, pulses;
    w = 0; pulses = 0;
    stake = 32'd1000; reliability_score = 32'd500; sla_id_i = 32'd77; timestamp_i = 32'd88;
    req_valid = 1'b1;
    while (!req_ready && w < 300) begin
      tick();
      w++;
    end
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (settlement_valid) pulses++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({settlement_a, settlement_b, settlement_c, remaining_stake, sla_status,
         sla_id_o, timestamp_o, reliability_score_o, settlement_valid} !== '0 ||
        req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_reset_clear: a=%0d rem=%0d st=%h id=%h valid=%b ready=%b required zeros and ready=1",
               settlement_a, remaining_stake, sla_status, sla_id_o, settlement_valid, req_ready);
    end
    tick(); tick();
    rst = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (settlement_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL midop_reset_no_valid: pulses=%0d required 0", pulses);
    end
    run_vector("after_reset", 32'd1000, 32'd850, 32'd200, 32'd120, 32'd60, 32'd20, 32'd800, 8'h02);
  endtask

  initial begin
    test_reset();
    test_tiers();
    test_boundaries();
    test_edge_values();
    test_back_to_back();
    test_cap();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
